// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one req/ack memory port; ARB_ROUND_ROBIN_EN selects round-robin grant.
// Latency: done 1 cycle after m_ack (>=2 cycles from request); requesters hold req until done, no queueing.
module unified_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_done_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_ack_i,
   output logic              err_o,
   output logic              busy_o
);

   localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;      // 1 = data port, 0 = fetch port
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                m_we_q, m_we_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                err_q, err_d;
   logic                grant_d;
   logic                timeout;

`ifdef ARB_ROUND_ROBIN_EN
   logic                last_owner_q, last_owner_d;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) last_owner_q <= 1'b0;
      else          last_owner_q <= last_owner_d;
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_q == S_RESP) last_owner_d = owner_q;
   end

   // On contention the port that did not go last wins; a lone requester always wins.
   assign grant_d = (d_req_i && if_req_i) ? ~last_owner_q : d_req_i;
`else
   assign grant_d = d_req_i;
`endif

   assign timeout = (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (d_req_i || if_req_i) begin
               owner_d = grant_d;
               cnt_d   = '0;
               state_d = S_BUSY;
               if (grant_d) begin
                  m_we_d    = d_we_i;
                  m_addr_d  = d_addr_i;
                  m_wdata_d = d_we_i ? d_wdata_i : '0;
               end else begin
                  m_we_d    = 1'b0;
                  m_addr_d  = if_addr_i;
                  m_wdata_d = '0;
               end
            end
         end
         S_BUSY: begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            // Ack takes precedence over a timeout landing in the same cycle.
            if (m_ack_i) begin
               err_d   = 1'b0;
               state_d = S_RESP;
               if (owner_q && !m_we_q) d_rdata_d  = m_rdata_i;
               else if (!owner_q)      if_rdata_d = m_rdata_i;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign m_req_o    = (state_q == S_BUSY);
   assign m_we_o     = m_we_q;
   assign m_addr_o   = m_addr_q;
   assign m_wdata_o  = m_wdata_q;
   assign if_rdata_o = if_rdata_q;
   assign d_rdata_o  = d_rdata_q;
   assign if_done_o  = (state_q == S_RESP) && !owner_q;
   assign d_done_o   = (state_q == S_RESP) && owner_q;
   assign err_o      = (state_q == S_RESP) && err_q;
   assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected memory requests and completions are queued by stimulus, checked by monitors.
module tb_unified_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int WM = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          if_req, if_done, d_req, d_we, d_done;
   logic [AW-1:0] if_addr, d_addr, m_addr;
   logic [DW-1:0] if_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
   logic          m_req, m_we, m_ack, err, busy;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
      .clk_i(clk), .reset_i(reset_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_done_o(if_done),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_rdata_o(d_rdata), .d_done_o(d_done),
      .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
      .m_rdata_i(m_rdata), .m_ack_i(m_ack), .err_o(err), .busy_o(busy)
   );

   typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mreq_t;
   typedef struct packed { logic is_d; logic [DW-1:0] rdata; logic err; } done_t;

   mreq_t         exp_m[$];
   done_t         exp_d[$];
   mreq_t         mem_e;
   done_t         mon_e;
   logic [DW-1:0] mdl_if_rdata, mdl_d_rdata;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            ack_delay = 1;
   int            busy_cnt = 0;
   int            last_mreq_len = 0;
   int            sv_if_cyc, sv_d_cyc, t0;

   always @(posedge clk) cyc++;

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      case (a)
         32'h10:  return 32'h00A0_0093;
         32'h200: return 32'h1122_3344;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic exp_if(input logic [AW-1:0] a);
      exp_m.push_back('{we: 1'b0, addr: a, wdata: '0});
      mdl_if_rdata = mem_val(a);
      exp_d.push_back('{is_d: 1'b0, rdata: mdl_if_rdata, err: 1'b0});
   endtask

   task automatic exp_dload(input logic [AW-1:0] a, input logic timeout);
      exp_m.push_back('{we: 1'b0, addr: a, wdata: '0});
      if (!timeout) mdl_d_rdata = mem_val(a);
      exp_d.push_back('{is_d: 1'b1, rdata: mdl_d_rdata, err: timeout});
   endtask

   task automatic exp_dstore(input logic [AW-1:0] a, input logic [DW-1:0] wd);
      exp_m.push_back('{we: 1'b1, addr: a, wdata: wd});
      exp_d.push_back('{is_d: 1'b1, rdata: mdl_d_rdata, err: 1'b0});
   endtask

   // Wait for n completions; requesters drop on their own done unless hold is set.
   task automatic serve(input int n, input bit hold);
      int got = 0;
      int lim = 0;
      while (got < n && lim < 200) begin
         @(negedge clk);
         lim++;
         if (if_done) begin got++; sv_if_cyc = cyc; if (!hold) if_req = 1'b0; end
         if (d_done)  begin got++; sv_d_cyc  = cyc; if (!hold) d_req  = 1'b0; end
      end
      if (got < n) begin
         checks++; errors++;
         $display("FAIL serve_timeout: got %0d dones expected %0d", got, n);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   // Memory model: acks on the ack_delay-th BUSY cycle (0 = never) and checks each new request.
   always @(negedge clk) begin
      if (m_req) begin
         busy_cnt++;
         if (busy_cnt == 1) begin
            if (exp_m.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mreq: got addr 0x%0h expected none", m_addr);
            end else begin
               mem_e = exp_m.pop_front();
               check("m_we", m_we, mem_e.we);
               check("m_addr", m_addr, mem_e.addr);
               check("m_wdata", m_wdata, mem_e.wdata);
            end
         end
         m_ack   = (ack_delay != 0) && (busy_cnt == ack_delay);
         m_rdata = m_ack ? mem_val(m_addr) : 32'hBAD0_BAD0;
      end else begin
         if (busy_cnt != 0) last_mreq_len = busy_cnt;
         busy_cnt = 0;
         m_ack    = 1'b0;
         m_rdata  = 32'hBAD0_BAD0;
      end
   end

   always @(negedge clk) begin
      if (if_done || d_done) begin
         check("done_exclusive", {1'b0, if_done && d_done}, 0);
         if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got if_done=%0b d_done=%0b expected none", if_done, d_done);
         end else begin
            mon_e = exp_d.pop_front();
            check("done_owner", d_done, mon_e.is_d);
            check("rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
            check("err", err, mon_e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
      mdl_if_rdata = '0; mdl_d_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_m_req", m_req, 0);
      check("rst_busy", busy, 0);
      check("rst_dones", {if_done, d_done, err}, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      reset_n = 1'b1;

      // 1: single fetch, ack on second BUSY cycle
      @(negedge clk);
      ack_delay = 2; exp_if(32'h10);
      if_addr = 32'h10; if_req = 1'b1; t0 = cyc;
      serve(1, 1'b0);
      check("t1_latency", sv_if_cyc - t0, 3);

      // 2: simultaneous requests, data port first then fetch
      repeat (2) @(negedge clk);
      ack_delay = 1;
      exp_dload(32'h200, 1'b0); exp_if(32'h20);
      d_we = 1'b0; d_addr = 32'h200; if_addr = 32'h20; d_req = 1'b1; if_req = 1'b1;
      serve(2, 1'b0);
      check("t2_if_after_d", sv_if_cyc - sv_d_cyc, 3);

      // 3: both held for four accesses
      repeat (2) @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_dload(32'h300, 1'b0); exp_if(32'h24); exp_dload(32'h300, 1'b0); exp_if(32'h24);
`else
      for (int i = 0; i < 4; i++) exp_dload(32'h300, 1'b0);
`endif
      d_addr = 32'h300; if_addr = 32'h24; d_req = 1'b1; if_req = 1'b1;
      serve(4, 1'b1);

      // 4: load with no ack times out after WAIT_MAX BUSY cycles
      repeat (2) @(negedge clk);
      ack_delay = 0; exp_dload(32'h80, 1'b1);
      d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
      serve(1, 1'b0);
      @(negedge clk);
      check("t4_mreq_len", last_mreq_len, WM);

      // 5: store leaves d_rdata untouched
      repeat (2) @(negedge clk);
      ack_delay = 1; exp_dstore(32'h40, 32'hDEAD_BEEF);
      d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
      serve(1, 1'b0);
      d_we = 1'b0;

      // 6: reset mid-BUSY, then a fresh fetch
      repeat (2) @(negedge clk);
      ack_delay = 0;
      exp_m.push_back('{we: 1'b0, addr: 32'h44, wdata: '0});
      if_addr = 32'h44; if_req = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_pre_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_m_req", m_req, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_dones", {if_done, d_done, err}, 0);
      if_req = 1'b0; mdl_if_rdata = '0; mdl_d_rdata = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      ack_delay = 1; exp_if(32'h48);
      if_addr = 32'h48; if_req = 1'b1; t0 = cyc;
      serve(1, 1'b0);
      check("t6_latency", sv_if_cyc - t0, 2);

      repeat (3) @(negedge clk);
      check("exp_done_drained", exp_d.size(), 0);
      check("exp_mreq_drained", exp_m.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
